// File: rtl/vga_fb_pkg.sv
// Shared widths, register offsets, reset colours and clear-engine states for the
// VGA frame buffer.
package vga_fb_pkg;

  localparam int FB_X_BITS    = 8;
  localparam int FB_Y_BITS    = 7;
  localparam int FB_ADDR_BITS = FB_X_BITS + FB_Y_BITS;

  localparam logic [7:0] REG_X      = 8'd0;
  localparam logic [7:0] REG_Y      = 8'd1;
  localparam logic [7:0] REG_PIXEL  = 8'd2;
  localparam logic [7:0] REG_FG     = 8'd3;
  localparam logic [7:0] REG_BG     = 8'd4;
  localparam logic [7:0] REG_CTRL   = 8'd5;
  localparam logic [7:0] REG_STATUS = 8'd6;

  localparam logic [7:0] RESET_FG = 8'hFF;
  localparam logic [7:0] RESET_BG = 8'h00;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_CLEAR = 1'b1
  } clrState_e;

endpackage

// File: rtl/fb_dual_port_ram.sv
// 1-bit-wide pixel storage: one write port, one registered read port for the
// display, plus a registered bus read-back port when FB_READBACK_EN is defined.
module fb_dual_port_ram
  import vga_fb_pkg::*;
#(
  parameter int ADDR_BITS = FB_ADDR_BITS
) (
  input  logic                 i_clk,
  input  logic                 i_rstN,
  input  logic                 i_weA,
  input  logic [ADDR_BITS-1:0] i_addrA,
  input  logic                 i_dinA,
  input  logic [ADDR_BITS-1:0] i_addrB,
  output logic                 o_doutB
`ifdef FB_READBACK_EN
  ,
  input  logic                 i_enC,
  input  logic [ADDR_BITS-1:0] i_addrC,
  output logic                 o_doutC
`endif
);

  localparam int DEPTH = 1 << ADDR_BITS;

  logic r_mem [DEPTH];
  logic r_doutB;

  always_ff @(posedge i_clk) begin
    if (i_weA) r_mem[i_addrA] <= i_dinA;
  end

  // Non-blocking reads of r_mem give read-first behaviour on address collisions.
  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN) r_doutB <= 1'b0;
    else         r_doutB <= r_mem[i_addrB];
  end

  assign o_doutB = r_doutB;

`ifdef FB_READBACK_EN
  logic r_doutC;

  always_ff @(posedge i_clk or negedge i_rstN) begin
    if (!i_rstN)    r_doutC <= 1'b0;
    else if (i_enC) r_doutC <= r_mem[i_addrC];
  end

  assign o_doutC = r_doutC;
`endif

endmodule

// File: rtl/vga_frame_buffer.sv
// 1bpp frame buffer with bus register block and a fill/clear engine.
// Optional macro FB_READBACK_EN enables bus read-back of the pixel at {Y,X}.
module vga_frame_buffer
  import vga_fb_pkg::*;
#(
  parameter int         X_BITS    = FB_X_BITS,
  parameter int         Y_BITS    = FB_Y_BITS,
  parameter logic [7:0] BASE_ADDR = 8'hB0
) (
  input  logic                     CLK,
  input  logic                     RESET,
  input  logic [7:0]               BUS_ADDR,
  input  logic [7:0]               BUS_WDATA,
  input  logic                     BUS_WE,
  input  logic                     BUS_RE,
  output logic [7:0]               BUS_RDATA,
  input  logic [X_BITS+Y_BITS-1:0] VGA_ADDR,
  output logic                     VGA_DATA,
  output logic [15:0]              CONFIG_COLOURS,
  output logic                     CLR_BUSY
);

  localparam int ADDR_BITS = X_BITS + Y_BITS;
  localparam logic [ADDR_BITS-1:0] LAST_ADDR = '1;

  logic [X_BITS-1:0]    r_x;
  logic [Y_BITS-1:0]    r_y;
  logic [7:0]           r_fg;
  logic [7:0]           r_bg;
  logic                 r_overrun;
  logic [7:0]           r_rdata;
  clrState_e            r_state;
  logic [ADDR_BITS-1:0] r_clrAddr;
  logic                 r_fill;
  logic                 r_busy;

  logic [7:0]           w_offset;
  logic                 w_hit;
  logic                 w_pixelWr;
  logic                 w_ctrlStart;
  logic                 w_statusRd;
  logic [7:0]           w_rdValue;
  logic                 w_clearing;
  logic                 w_weA;
  logic [ADDR_BITS-1:0] w_addrA;
  logic                 w_dinA;

  // Offset decode; the >= guard stops addresses below the base wrapping into the block.
  assign w_offset    = BUS_ADDR - BASE_ADDR;
  assign w_hit       = (BUS_ADDR >= BASE_ADDR) && (w_offset <= REG_STATUS);
  assign w_pixelWr   = BUS_WE && w_hit && (w_offset == REG_PIXEL);
  assign w_ctrlStart = BUS_WE && w_hit && (w_offset == REG_CTRL) && BUS_WDATA[0];
  assign w_statusRd  = BUS_RE && w_hit && (w_offset == REG_STATUS);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_x       <= '0;
      r_y       <= '0;
      r_fg      <= RESET_FG;
      r_bg      <= RESET_BG;
      r_overrun <= 1'b0;
    end else begin
      if (BUS_WE && w_hit && (w_offset == REG_X))  r_x  <= BUS_WDATA[X_BITS-1:0];
      if (BUS_WE && w_hit && (w_offset == REG_Y))  r_y  <= BUS_WDATA[Y_BITS-1:0];
      if (BUS_WE && w_hit && (w_offset == REG_FG)) r_fg <= BUS_WDATA;
      if (BUS_WE && w_hit && (w_offset == REG_BG)) r_bg <= BUS_WDATA;
      if (w_pixelWr && r_busy)                     r_overrun <= 1'b1;
      else if (w_statusRd)                         r_overrun <= 1'b0;
    end
  end

  always_comb begin
    w_rdValue = 8'h00;
    if (w_hit) begin
      case (w_offset)
        REG_X:      w_rdValue = 8'(r_x);
        REG_Y:      w_rdValue = 8'(r_y);
        REG_FG:     w_rdValue = r_fg;
        REG_BG:     w_rdValue = r_bg;
        REG_STATUS: w_rdValue = {6'b0, r_overrun, r_busy};
        default:    w_rdValue = 8'h00;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      r_rdata <= 8'h00;
    else if (BUS_RE) r_rdata <= w_rdValue;
  end

  // Reset parks the engine in CLEAR at address 0 so a zero fill runs on release.
  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET) begin
      r_state   <= ST_CLEAR;
      r_clrAddr <= '0;
      r_fill    <= 1'b0;
      r_busy    <= 1'b1;
    end else if (w_ctrlStart) begin
      r_state   <= ST_CLEAR;
      r_clrAddr <= '0;
      r_fill    <= BUS_WDATA[1];
      r_busy    <= 1'b1;
    end else if (r_state == ST_CLEAR) begin
      r_clrAddr <= r_clrAddr + 1'b1;
      if (r_clrAddr == LAST_ADDR) begin
        r_state <= ST_IDLE;
        r_busy  <= 1'b0;
      end
    end else begin
      r_busy <= 1'b0;
    end
  end

  assign w_clearing = (r_state == ST_CLEAR);
  assign w_weA      = w_clearing ? 1'b1      : w_pixelWr;
  assign w_addrA    = w_clearing ? r_clrAddr : {r_y, r_x};
  assign w_dinA     = w_clearing ? r_fill    : BUS_WDATA[0];

`ifdef FB_READBACK_EN
  logic w_pixelRd;
  logic w_pixelRdData;
  logic r_rdPixel;

  assign w_pixelRd = BUS_RE && w_hit && (w_offset == REG_PIXEL);

  always_ff @(posedge CLK or negedge RESET) begin
    if (!RESET)      r_rdPixel <= 1'b0;
    else if (BUS_RE) r_rdPixel <= w_pixelRd;
  end

  assign BUS_RDATA = r_rdPixel ? {7'b0, w_pixelRdData} : r_rdata;

  fb_dual_port_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .i_clk   (CLK),
    .i_rstN  (RESET),
    .i_weA   (w_weA),
    .i_addrA (w_addrA),
    .i_dinA  (w_dinA),
    .i_addrB (VGA_ADDR),
    .o_doutB (VGA_DATA),
    .i_enC   (w_pixelRd),
    .i_addrC ({r_y, r_x}),
    .o_doutC (w_pixelRdData)
  );
`else
  assign BUS_RDATA = r_rdata;

  fb_dual_port_ram #(.ADDR_BITS(ADDR_BITS)) u_ram (
    .i_clk   (CLK),
    .i_rstN  (RESET),
    .i_weA   (w_weA),
    .i_addrA (w_addrA),
    .i_dinA  (w_dinA),
    .i_addrB (VGA_ADDR),
    .o_doutB (VGA_DATA)
  );
`endif

  assign CONFIG_COLOURS = {r_bg, r_fg};
  assign CLR_BUSY       = r_busy;

endmodule

// File: tb/tb_vga_frame_buffer.sv
// Scoreboard bench for vga_frame_buffer: directed vectors queue their expected
// response, a monitor compares it one cycle later.
module tb_vga_frame_buffer;
  import vga_fb_pkg::*;

  localparam logic [7:0] BASE     = 8'hB0;
  localparam logic [7:0] A_X      = BASE + REG_X;
  localparam logic [7:0] A_Y      = BASE + REG_Y;
  localparam logic [7:0] A_PIXEL  = BASE + REG_PIXEL;
  localparam logic [7:0] A_FG     = BASE + REG_FG;
  localparam logic [7:0] A_BG     = BASE + REG_BG;
  localparam logic [7:0] A_CTRL   = BASE + REG_CTRL;
  localparam logic [7:0] A_STATUS = BASE + REG_STATUS;

  localparam int K_NONE    = 0;
  localparam int K_RDATA   = 1;
  localparam int K_VGA     = 2;
  localparam int K_COLOURS = 3;

`ifdef FB_READBACK_EN
  localparam logic [7:0] EXP_READBACK = 8'h01;
`else
  localparam logic [7:0] EXP_READBACK = 8'h00;
`endif

  typedef struct {
    int          kind;
    logic [15:0] exp;
    string       name;
  } expect_t;

  logic        CLK = 1'b0;
  logic        RESET;
  logic [7:0]  BUS_ADDR;
  logic [7:0]  BUS_WDATA;
  logic        BUS_WE;
  logic        BUS_RE;
  logic [7:0]  BUS_RDATA;
  logic [14:0] VGA_ADDR;
  logic        VGA_DATA;
  logic [15:0] CONFIG_COLOURS;
  logic        CLR_BUSY;

  expect_t     sb[$];
  logic        tbReq = 1'b0;
  logic        reqDly = 1'b0;
  int          cycleCnt = 0;
  int          passChecks = 0;
  int          totalChecks = 0;
  int          startCyc;
  expect_t     mon;
  logic [15:0] monAct;

  vga_frame_buffer #(.X_BITS(8), .Y_BITS(7), .BASE_ADDR(BASE)) dut (
    .CLK            (CLK),
    .RESET          (RESET),
    .BUS_ADDR       (BUS_ADDR),
    .BUS_WDATA      (BUS_WDATA),
    .BUS_WE         (BUS_WE),
    .BUS_RE         (BUS_RE),
    .BUS_RDATA      (BUS_RDATA),
    .VGA_ADDR       (VGA_ADDR),
    .VGA_DATA       (VGA_DATA),
    .CONFIG_COLOURS (CONFIG_COLOURS),
    .CLR_BUSY       (CLR_BUSY)
  );

  always #5 CLK = ~CLK;

  always @(posedge CLK) begin
    cycleCnt <= cycleCnt + 1;
    reqDly   <= tbReq;
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    totalChecks++;
    if (act === exp) passChecks++;
    else $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  // Output for a request registered at edge P is sampled on the negedge after P.
  always @(negedge CLK) begin
    if (reqDly) begin
      if (sb.size() == 0) begin
        checkOutput("sb_underflow", 1, 0);
      end else begin
        mon = sb.pop_front();
        case (mon.kind)
          K_RDATA: monAct = {8'h00, BUS_RDATA};
          K_VGA:   monAct = {15'h0000, VGA_DATA};
          default: monAct = CONFIG_COLOURS;
        endcase
        checkOutput(mon.name, monAct, mon.exp);
      end
    end
  end

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic applyStimulus(input logic we, input logic re, input logic [7:0] addr,
                               input logic [7:0] wdata, input logic [14:0] vaddr,
                               input int kind, input logic [15:0] exp, input string name);
    expect_t e;
    BUS_WE    = we;
    BUS_RE    = re;
    BUS_ADDR  = addr;
    BUS_WDATA = wdata;
    VGA_ADDR  = vaddr;
    if (kind != K_NONE) begin
      e.kind = kind;
      e.exp  = exp;
      e.name = name;
      sb.push_back(e);
      tbReq = 1'b1;
    end
    tick();
    BUS_WE = 1'b0;
    BUS_RE = 1'b0;
    tbReq  = 1'b0;
  endtask

  task automatic busWrite(input logic [7:0] addr, input logic [7:0] data);
    applyStimulus(1'b1, 1'b0, addr, data, 15'h0000, K_NONE, 16'h0000, "");
  endtask

  task automatic busRead(input logic [7:0] addr, input logic [7:0] exp, input string name);
    applyStimulus(1'b0, 1'b1, addr, 8'h00, 15'h0000, K_RDATA, {8'h00, exp}, name);
  endtask

  task automatic vgaRead(input logic [14:0] vaddr, input logic exp, input string name);
    applyStimulus(1'b0, 1'b0, 8'h00, 8'h00, vaddr, K_VGA, {15'h0000, exp}, name);
  endtask

  task automatic measureBusy(input string name);
    int cnt = 0;
    @(negedge CLK);
    while (CLR_BUSY && cnt < 40000) begin
      cnt++;
      @(negedge CLK);
    end
    checkOutput(name, cnt, 32768);
    tick();
  endtask

  initial begin
    #3000000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    RESET     = 1'b0;
    BUS_ADDR  = 8'h00;
    BUS_WDATA = 8'h00;
    BUS_WE    = 1'b0;
    BUS_RE    = 1'b0;
    VGA_ADDR  = 15'h0000;

    repeat (3) @(posedge CLK);
    @(negedge CLK);
    checkOutput("rst_busy", CLR_BUSY, 1);
    checkOutput("rst_colours", CONFIG_COLOURS, 16'h00FF);
    checkOutput("rst_rdata", BUS_RDATA, 0);
    checkOutput("rst_vga", VGA_DATA, 0);

    // Release, run ~1000 cycles of the power-on clear, then abort it with reset.
    tick();
    RESET = 1'b1;
    busWrite(A_FG, 8'h12);
    repeat (998) tick();
    checkOutput("pre_abort_colours", CONFIG_COLOURS, 16'h0012);
    checkOutput("pre_abort_busy", CLR_BUSY, 1);
    RESET = 1'b0;
    #1;
    checkOutput("abort_busy", CLR_BUSY, 1);
    checkOutput("abort_colours", CONFIG_COLOURS, 16'h00FF);
    tick();
    tick();
    RESET = 1'b1;
    measureBusy("reset_busy_window");

    vgaRead(15'h0000, 1'b0, "zero_vga_0000");
    vgaRead(15'h7FFF, 1'b0, "zero_vga_7fff");
    busRead(A_STATUS, 8'h00, "status_idle");

    busWrite(A_X, 8'h05);
    busWrite(A_Y, 8'h03);
    busWrite(A_PIXEL, 8'h01);
    vgaRead(15'h0305, 1'b1, "pix_set");
    vgaRead(15'h0304, 1'b0, "pix_neighbour");
    busRead(A_X, 8'h05, "rd_x");
    busRead(A_Y, 8'h03, "rd_y");
    applyStimulus(1'b1, 1'b0, A_FG, 8'hE0, 15'h0000, K_RDATA, 16'h0003, "rdata_hold");
    applyStimulus(1'b1, 1'b0, A_BG, 8'h1C, 15'h0000, K_COLOURS, 16'h1CE0, "colours");
    busRead(A_FG, 8'hE0, "rd_fg");
    busRead(A_BG, 8'h1C, "rd_bg");
    applyStimulus(1'b1, 1'b1, A_X, 8'h10, 15'h0000, K_RDATA, 16'h0005, "rw_same_cycle");
    busRead(A_X, 8'h10, "rd_x_new");
    applyStimulus(1'b1, 1'b0, A_PIXEL, 8'h01, 15'h0310, K_VGA, 16'h0000, "vga_read_first");
    vgaRead(15'h0310, 1'b1, "vga_after_write");
    busWrite(8'hB7, 8'hFF);
    busRead(8'hB7, 8'h00, "unmapped_b7");
    busRead(8'hAF, 8'h00, "unmapped_af");
    busWrite(A_X, 8'h9F);
    busWrite(A_Y, 8'h77);
    busWrite(A_PIXEL, 8'h01);
    busRead(A_PIXEL, EXP_READBACK, "pixel_readback");
    vgaRead(15'h779F, 1'b1, "pix_edge");
    busRead(A_STATUS, 8'h00, "status_no_overrun");

    // Fill with ones; a pixel write of 0 at {0,0} mid-clear must be dropped.
    busWrite(A_X, 8'h00);
    busWrite(A_Y, 8'h00);
    busWrite(A_CTRL, 8'h03);
    startCyc = cycleCnt;
    repeat (3) tick();
    busWrite(A_PIXEL, 8'h00);
    busRead(A_STATUS, 8'h03, "status_overrun");
    busRead(A_STATUS, 8'h01, "status_reread");
    for (int i = 0; i < 40000; i++) begin
      @(negedge CLK);
      if (!CLR_BUSY) break;
    end
    checkOutput("ctrl_clear_len", cycleCnt - startCyc, 32768);
    checkOutput("ctrl_busy_done", CLR_BUSY, 0);
    tick();
    vgaRead(15'h0000, 1'b1, "ones_0000");
    vgaRead(15'h0001, 1'b1, "ones_0001");
    vgaRead(15'h0304, 1'b1, "ones_0304");
    vgaRead(15'h0305, 1'b1, "ones_0305");
    vgaRead(15'h779F, 1'b1, "ones_779f");
    vgaRead(15'h4000, 1'b1, "ones_4000");
    vgaRead(15'h7FFF, 1'b1, "ones_7fff");
    busRead(A_STATUS, 8'h00, "status_after_clear");

    repeat (3) tick();
    checkOutput("sb_drain", sb.size(), 0);
    $display("%0d/%0d checks passed", passChecks, totalChecks);
    $finish;
  end

endmodule
